// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package instr_fetch_unit_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StIssue = 2'd2,
    StError = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_add.sv
// Plain combinational adder; used as the PC+4 incrementer.
module Add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum
);

  // Carry-out is dropped so the sum wraps modulo 2^WIDTH.
  assign Sum = A + B;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches one word at a time over a
// req/ready + valid handshake and hands instruction/PC+4 to the datapath.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_imemReq,
  output logic [31:0]        o_imemAddr,
  input  logic               i_imemReady,
  input  logic               i_imemValid,
  input  logic [31:0]        i_imemData,
  output logic [31:0]        o_instruction,
  output logic [31:0]        o_pcPlus4,
  output logic               o_instValid,
  input  logic               i_instReady,
  input  logic [31:0]        i_nextPC,
  output logic               o_fetchErr,
  output logic [31:0]        o_errAddr,
  output logic [CNT_W-1:0]   o_retired
);

  localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc_plus4_q, pc_plus4_d;
  logic               inst_valid_q, inst_valid_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [31:0]        pc_plus4;

  Add #(
    .WIDTH(32)
  ) u_pc_incr (
    .A  (pc_q),
    .B  (PC_INCR),
    .Sum(pc_plus4)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    inst_valid_d = inst_valid_q;
    err_addr_d   = err_addr_q;
    retired_d    = retired_q;
    timer_d      = timer_q;

    unique case (state_q)
      StReq: begin
        // Any response seen here is ignored: only one request is ever outstanding.
        if (i_imemReady) begin
          state_d = StWait;
          timer_d = '0;
        end
      end
      StWait: begin
        // A response arriving on the timeout cycle still wins.
        if (i_imemValid) begin
          instr_d      = i_imemData;
          pc_plus4_d   = pc_plus4;
          inst_valid_d = 1'b1;
          state_d      = StIssue;
        end else if (timer_q == TimerMax) begin
          err_addr_d = pc_q;
          state_d    = StError;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StIssue: begin
        if (i_instReady) begin
          inst_valid_d = 1'b0;
          if (is_word_aligned(i_nextPC)) begin
            pc_d      = i_nextPC;
            retired_d = retired_q + CNT_W'(1);
            state_d   = StReq;
          end else begin
            err_addr_d = i_nextPC;
            state_d    = StError;
          end
        end
      end
      StError: begin
        inst_valid_d = 1'b0;
      end
      default: begin
        state_d = StError;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      pc_plus4_q   <= '0;
      inst_valid_q <= 1'b0;
      err_addr_q   <= '0;
      retired_q    <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      inst_valid_q <= inst_valid_d;
      err_addr_q   <= err_addr_d;
      retired_q    <= retired_d;
      timer_q      <= timer_d;
    end
  end

  assign o_imemReq     = (state_q == StReq);
  assign o_imemAddr    = pc_q;
  assign o_instruction = instr_q;
  assign o_pcPlus4     = pc_plus4_q;
  assign o_instValid   = inst_valid_q;
  assign o_fetchErr    = (state_q == StError);
  assign o_errAddr     = err_addr_q;
  assign o_retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue scoreboard of fetched words.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemReady;
  logic        i_imemValid;
  logic [31:0] i_imemData;
  logic [31:0] o_instruction;
  logic [31:0] o_pcPlus4;
  logic        o_instValid;
  logic        i_instReady;
  logic [31:0] i_nextPC;
  logic        o_fetchErr;
  logic [31:0] o_errAddr;
  logic [31:0] o_retired;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  exp_t        sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16),
    .CNT_W   (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_imemReq    (o_imemReq),
    .o_imemAddr   (o_imemAddr),
    .i_imemReady  (i_imemReady),
    .i_imemValid  (i_imemValid),
    .i_imemData   (i_imemData),
    .o_instruction(o_instruction),
    .o_pcPlus4    (o_pcPlus4),
    .o_instValid  (o_instValid),
    .i_instReady  (i_instReady),
    .i_nextPC     (i_nextPC),
    .o_fetchErr   (o_fetchErr),
    .o_errAddr    (o_errAddr),
    .o_retired    (o_retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, o_imemReq, 1);
    check({tag, "_addr"}, o_imemAddr, 32'h0);
    check({tag, "_instr"}, o_instruction, 32'h0);
    check({tag, "_pcp4"}, o_pcPlus4, 32'h0);
    check({tag, "_ivalid"}, o_instValid, 0);
    check({tag, "_err"}, o_fetchErr, 0);
    check({tag, "_erraddr"}, o_errAddr, 32'h0);
    check({tag, "_retired"}, o_retired, 32'h0);
  endtask

  // One full fetch: rdly cycles of ready=0, vdly WAIT cycles before valid,
  // cdly ISSUE cycles before the datapath consumes.
  task automatic do_fetch(input logic [31:0] data, input logic [31:0] nextpc,
                          input int rdly, input int vdly, input int cdly);
    exp_t e;
    check("req_start", o_imemReq, 1);
    check("addr_start", o_imemAddr, exp_pc);
    i_imemReady = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      tick();
      check("req_hold", o_imemReq, 1);
      check("addr_hold", o_imemAddr, exp_pc);
      check("err_hold", o_fetchErr, 0);
    end
    i_imemReady = 1'b1;
    tick();
    i_imemReady = 1'b0;
    check("req_in_wait", o_imemReq, 0);
    for (int i = 0; i < vdly; i++) tick();
    i_imemValid = 1'b1;
    i_imemData  = data;
    sb.push_back('{instr: data, pcp4: exp_pc + 32'd4});
    tick();
    i_imemValid = 1'b0;
    check("ivalid_issue", o_instValid, 1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check("instr", o_instruction, e.instr);
    check("pcp4", o_pcPlus4, e.pcp4);
    for (int i = 0; i < cdly; i++) begin
      tick();
      check("ivalid_stall", o_instValid, 1);
      check("instr_stall", o_instruction, e.instr);
      check("pcp4_stall", o_pcPlus4, e.pcp4);
      check("addr_stall", o_imemAddr, exp_pc);
    end
    i_instReady = 1'b1;
    i_nextPC    = nextpc;
    tick();
    i_instReady = 1'b0;
    check("ivalid_after", o_instValid, 0);
    if (nextpc[1:0] == 2'b00) begin
      exp_pc  = nextpc;
      exp_ret = exp_ret + 32'd1;
      check("req_next", o_imemReq, 1);
      check("addr_next", o_imemAddr, exp_pc);
      check("retired", o_retired, exp_ret);
      check("err_clear", o_fetchErr, 0);
    end else begin
      check("err_misalign", o_fetchErr, 1);
      check("erraddr_misalign", o_errAddr, nextpc);
      check("req_err", o_imemReq, 0);
      check("retired_err", o_retired, exp_ret);
    end
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    i_imemReady = 1'b0;
    i_imemValid = 1'b0;
    i_imemData  = '0;
    i_instReady = 1'b0;
    i_nextPC    = '0;
    exp_pc      = 32'h0;
    exp_ret     = 32'h0;
    #1;
    check_reset_vals("rst");
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Back-to-back best-case fetch, then stalls and a branch.
    do_fetch(32'h2002_0005, 32'h0000_0004, 0, 0, 0);
    do_fetch(32'h1111_2222, 32'h0000_0040, 5, 0, 0);
    do_fetch(32'h3333_4444, 32'hFFFF_FFFC, 0, 2, 4);
    // PC+4 wraps to 0; valid on the 16th WAIT cycle still issues; then misalign.
    do_fetch(32'h5555_6666, 32'h0000_0042, 0, 15, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("err_sticky_req", o_imemReq, 0);
      check("err_sticky", o_fetchErr, 1);
      check("err_sticky_ivalid", o_instValid, 0);
    end

    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_err");
    #2 rst_n = 1'b1;
    exp_pc  = 32'h0;
    exp_ret = 32'h0;
    tick();
    do_fetch(32'h0BAD_F00D, 32'h0000_0008, 0, 0, 0);

    // Memory never responds.
    i_imemReady = 1'b1;
    tick();
    i_imemReady = 1'b0;
    n = 0;
    while (!o_fetchErr && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 16);
    check("timeout_erraddr", o_errAddr, exp_pc);
    tick();
    check("timeout_req", o_imemReq, 0);
    check("timeout_retired", o_retired, exp_ret);

    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_to");
    #2 rst_n = 1'b1;
    exp_pc  = 32'h0;
    exp_ret = 32'h0;
    tick();
    do_fetch(32'hCAFE_0001, 32'h0000_0010, 0, 0, 0);

    // Asynchronous reset in the middle of WAIT.
    i_imemReady = 1'b1;
    tick();
    i_imemReady = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_wait");
    #2 rst_n = 1'b1;
    tick();
    check("restart_addr", o_imemAddr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
